// File: rtl/sram_l0_loader.sv
// rtl/sram_l0_loader.sv - block copy engine from the SRAM macro into the L0 input FIFO
// Optional stall counter output enabled by defining LOADER_STALL_CNT_EN.
module sram_l0_loader #(
  parameter int DATA_BW = 32,
  parameter int ADDR_BW = 7,
  parameter int CNT_BW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW-1:0] base_addr,
  input  logic [CNT_BW-1:0]  num_words,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [ADDR_BW-1:0] sram_a,
  input  logic [DATA_BW-1:0] sram_q,
  input  logic               l0_full,
  output logic               l0_wr,
  output logic [DATA_BW-1:0] l0_in,
`ifdef LOADER_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [ADDR_BW-1:0] addr_reg;
  logic [CNT_BW-1:0]  remaining;
  logic               in_flight;
  logic               skid_valid;
  logic [DATA_BW-1:0] skid_data;

  logic issue;
  logic skid_push;
  logic ret_push;
  logic ret_capture;
  logic skid_valid_next;
  logic drain_clear;

  // A word waiting in the skid blocks both new reads and direct returns, so
  // at most one word is ever held and the skid can never be overwritten.
  always_comb begin
    issue           = !reset && (state == RUN) && !l0_full && !skid_valid;
    skid_push       = !reset && skid_valid && !l0_full;
    ret_push        = !reset && in_flight && !l0_full && !skid_valid;
    ret_capture     = in_flight && !ret_push;
    skid_valid_next = skid_valid;
    if (ret_capture) begin
      skid_valid_next = 1'b1;
    end else if (skid_push) begin
      skid_valid_next = 1'b0;
    end
    drain_clear = !issue && !skid_valid_next;
  end

  always_comb begin
    sram_cen = !issue;
    sram_wen = 1'b1;
    sram_a   = issue ? addr_reg : '0;
    l0_wr    = skid_push || ret_push;
    l0_in    = '0;
    if (skid_push) begin
      l0_in = skid_data;
    end else if (ret_push) begin
      l0_in = sram_q;
    end
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_reg   <= '0;
      remaining  <= '0;
      in_flight  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      in_flight  <= issue;
      skid_valid <= skid_valid_next;
      if (ret_capture) begin
        skid_data <= sram_q;
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr_reg  <= base_addr;
            remaining <= num_words;
            state     <= (num_words == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr_reg  <= addr_reg + ADDR_BW'(1);
            remaining <= remaining - CNT_BW'(1);
            if (remaining == CNT_BW'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_clear) begin
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_STALL_CNT_EN
  logic stall_event;

  always_comb begin
    stall_event = ((state == RUN) || (state == DRAIN)) && l0_full && (in_flight || skid_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (stall_event && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sram_l0_loader.md
Name: sram_l0_loader

Overview:
- Parametrised SRAM-to-L0 transfer engine. Sits in core between the activation/weight SRAM macro and the corelet L0 input FIFO.
- Replaces direct testbench driving of SRAM CEN/WEN/A: on a start pulse it reads a block of consecutive SRAM words and pushes them into L0.
- Handles the 1-cycle SRAM read latency and L0 backpressure without losing or duplicating words.

Parameters:
DATA_BW, 32, SRAM word / L0 input width in bits
ADDR_BW, 7, SRAM address width (depth 2^ADDR_BW)
CNT_BW, 8, width of transfer length field

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse, begins transfer (ignored unless IDLE)
base_addr  input  ADDR_BW  first SRAM address, sampled on accepted start
num_words  input  CNT_BW  words to transfer, sampled on accepted start
sram_cen  output  1  SRAM chip enable, active low
sram_wen  output  1  SRAM write enable, active low; held 1 (read only)
sram_a  output  ADDR_BW  SRAM address
sram_q  input  DATA_BW  SRAM read data, valid the cycle after cen low
l0_full  input  1  L0 FIFO cannot accept a write this cycle
l0_wr  output  1  L0 push strobe
l0_in  output  DATA_BW  L0 push data
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse on completion

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset.
- Reset values: sram_cen=1, sram_wen=1, sram_a=0, l0_wr=0, l0_in=0, busy=0, done=0. FSM returns to IDLE, skid buffer empty, in-flight flag clear.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start with num_words!=0. Latches base_addr into addr_reg, num_words into remaining.
  - IDLE -> DONE on start with num_words==0. No SRAM access; done pulses the next cycle.
  - RUN -> DRAIN in the cycle the last read is issued (remaining reaches 0).
  - DRAIN -> DONE when no read is in flight and the skid buffer is empty.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- Read issue in RUN: issue when l0_full==0 and skid empty. Issue means sram_cen=0, sram_a=addr_reg, then addr_reg+1 mod 2^ADDR_BW and remaining-1. Address wrap from 127 to 0 is legal.
- Return path: set an in-flight flag on issue. The next cycle sram_q is valid:
  - l0_full==0 and skid empty: l0_wr=1, l0_in=sram_q.
  - otherwise: capture into 1-entry skid.
- Skid drains with priority over new return data. Skid push occurs in any cycle with l0_full==0 and skid valid. No read is issued while skid is valid.
- l0_wr is never asserted while l0_full=1.
- Throughput: 1 word/cycle with L0 not full. Latency from start to first l0_wr is 2 cycles: start at t, issue at t+1, push at t+2.
- Word order: pushed in ascending address order, each address exactly once.
- start while busy or in DONE is ignored. Latched parameters are unchanged.
- Reset mid-operation: abort immediately, discard in-flight and skid data, no done pulse.

Optional Feature:
- Macro LOADER_STALL_CNT_EN.
- When defined: adds output stall_cnt [15:0]. It counts cycles in RUN or DRAIN where l0_full=1 and a word is pending (in-flight or skid), saturating at 16'hFFFF. It clears on accepted start and on reset.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Preload SRAM[0..15]=0x100+i. Start, base 0, num 16, l0_full=0 -> 16 pushes on consecutive cycles, data 0x100..0x10F. First push 2 cycles after start. done 1 cycle after DRAIN; busy low afterwards.
- Base 124, num 8 -> sram_a sequence 124,125,126,127,0,1,2,3. Pushed data in that order.
- Base 0, num 10, l0_full high for 3 cycles starting at the 4th push -> exactly 10 pushes, no duplicates or gaps, l0_wr never high with l0_full. With LOADER_STALL_CNT_EN: stall_cnt=3.
- num 0 -> no sram_cen low, no l0_wr, done pulse 1 cycle after start.
- Second start mid-transfer with different base -> ignored; original sequence completes.
- Reset asserted after 5 pushes of a 16-word transfer -> next cycle all outputs at reset values, no further l0_wr, no done. A new start then runs normally from its own base.
